// File: rtl/instruction_sequencer_if.sv
// Fetch and data-memory handshake bundle between the
// sequencer and the memory side.
interface instruction_sequencer_if #(
  parameter int INST_W = 16
);
  logic              imem_req;
  logic              imem_ready;
  logic [INST_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the turtle core:
// owns IR, the commit strobe, halt/run control and instret.
module instruction_sequencer #(
  parameter int INST_W        = 16,
  parameter int CNT_W         = 32,
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic              dmem_we_dec,
  input  logic              dmem_oe_dec,
  instruction_sequencer_if.master bus,
  output logic [INST_W-1:0] ir,
  output logic              commit,
  output logic              running,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_t;

  localparam int TO_W =
    (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  // Last wait value before the timeout fires.
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  state_t          state;
  state_t          next;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout;

  assign timeout = (FETCH_TIMEOUT != 0) &&
                   (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next         = state;
    commit       = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    running      = 1'b0;
    halted       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) next = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        running      = 1'b1;
        if (bus.imem_ready) next = S_DECODE;
        else if (timeout)   next = S_HALTED;
      end
      S_DECODE: begin
        running = 1'b1;
        if (dmem_we_dec || dmem_oe_dec) next = S_MEM;
        else                            next = S_EXEC;
      end
      S_EXEC: begin
        running = 1'b1;
        commit  = 1'b1;
        next    = halt_req ? S_HALTED : S_FETCH;
      end
      S_MEM: begin
        running      = 1'b1;
        bus.dmem_req = 1'b1;
        bus.dmem_we  = dmem_we_dec;
        if (bus.dmem_ready) begin
          commit = 1'b1;
          next   = halt_req ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        if (run) next = S_FETCH;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      instret  <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == S_FETCH && bus.imem_ready)
        ir <= bus.imem_rdata;
      if (commit)
        instret <= instret + CNT_W'(1);
      // Counts only while we stay in FETCH.
      if (state == S_FETCH && next == S_FETCH)
        wait_cnt <= wait_cnt + TO_W'(1);
      else
        wait_cnt <= '0;
      if (state == S_FETCH && next == S_HALTED)
        fault <= 1'b1;
      else if (state == S_HALTED && run)
        fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a commit
// scoreboard of expected IR and pre-commit instret.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        dmem_we_dec;
  logic        dmem_oe_dec;
  logic [15:0] ir;
  logic        commit;
  logic        running;
  logic        halted;
  logic        fault;
  logic [3:0]  instret;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  cnt;
  } exp_t;
  exp_t sb[$];

  instruction_sequencer_if #(.INST_W(16)) bus ();

  instruction_sequencer #(
    .INST_W(16),
    .CNT_W(4),
    .FETCH_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .halt_req(halt_req),
    .dmem_we_dec(dmem_we_dec),
    .dmem_oe_dec(dmem_oe_dec),
    .bus(bus),
    .ir(ir),
    .commit(commit),
    .running(running),
    .halted(halted),
    .fault(fault),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Stand-in decoder: 0004 is LOAD, 0014 is STORE.
  assign dmem_oe_dec = (ir == 16'h0004);
  assign dmem_we_dec = (ir == 16'h0014);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] i,
                      input logic [3:0] c);
    exp_t e;
    e.ir  = i;
    e.cnt = c;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: one entry per commit strobe.
  logic prev_commit = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (commit) begin
      check("commit_gap", {31'd0, prev_commit}, 32'd0);
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_unexpected: observed commit expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ir", {16'd0, ir}, {16'd0, e.ir});
        check("sb_instret", {28'd0, instret}, {28'd0, e.cnt});
      end
    end
    prev_commit = commit;
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    halt_req = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_outs",
          {bus.imem_req, bus.dmem_req, bus.dmem_we,
           commit, running, halted, fault}, 0);
    check("rst_ir", {16'd0, ir}, 0);
    check("rst_instret", {28'd0, instret}, 0);

    // Zero-wait ADDI stream: commit every third cycle.
    run = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h5500;
    push(16'h5500, 4'd0);
    push(16'h5500, 4'd1);
    push(16'h5500, 4'd2);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 9) begin
        halt_req = 1'b1;
        run = 1'b0;
      end
      #1;
      check("t1_commit", {31'd0, commit},
            (i % 3 == 0) ? 32'd1 : 32'd0);
      check("t1_instret", {28'd0, instret}, (i - 1) / 3);
      if (i == 2) check("t1_ir", {16'd0, ir}, 32'h5500);
    end
    tick();
    halt_req = 1'b0;
    #1;
    check("t1_halted", {31'd0, halted}, 1);
    check("t1_instret3", {28'd0, instret}, 3);
    check("t1_noreq", {31'd0, bus.imem_req}, 0);

    // LOAD with three MEM cycles, then one-cycle STORE.
    run = 1'b1;
    bus.imem_rdata = 16'h0004;
    push(16'h0004, 4'd3);
    tick();
    run = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        bus.dmem_ready = 1'b1;
        bus.imem_rdata = 16'h0014;
        push(16'h0014, 4'd4);
      end
      #1;
      check("t2_ld_req", {31'd0, bus.dmem_req}, 1);
      check("t2_ld_we", {31'd0, bus.dmem_we}, 0);
      check("t2_ld_commit", {31'd0, commit},
            (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    check("t2_fetch_noreq", {31'd0, bus.dmem_req}, 0);
    check("t2_instret4", {28'd0, instret}, 4);
    tick();
    tick();
    bus.dmem_ready = 1'b1;
    halt_req = 1'b1;
    #1;
    check("t2_st_req", {31'd0, bus.dmem_req}, 1);
    check("t2_st_we", {31'd0, bus.dmem_we}, 1);
    check("t2_st_commit", {31'd0, commit}, 1);
    tick();
    bus.dmem_ready = 1'b0;
    halt_req = 1'b0;
    #1;
    check("t2_halted", {31'd0, halted}, 1);
    check("t2_instret5", {28'd0, instret}, 5);

    // Fetch timeout after eight waiting cycles.
    bus.imem_ready = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("t3_req", {31'd0, bus.imem_req}, 1);
      check("t3_not_halted", {31'd0, halted}, 0);
      tick();
    end
    #1;
    check("t3_halted", {31'd0, halted}, 1);
    check("t3_fault", {31'd0, fault}, 1);
    check("t3_noreq", {31'd0, bus.imem_req}, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    #1;
    check("t3_fault_clr", {31'd0, fault}, 0);
    check("t3_req_again", {31'd0, bus.imem_req}, 1);

    // Ready on the timeout cycle wins.
    for (int k = 1; k <= 7; k++) tick();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 16'h5500;
    push(16'h5500, 4'd5);
    tick();
    bus.imem_ready = 1'b0;
    #1;
    check("t3_race_fault", {31'd0, fault}, 0);
    check("t3_race_run", {31'd0, running}, 1);
    check("t3_race_ir", {16'd0, ir}, 32'h5500);
    tick();
    tick();

    // halt_req during fetch wait is ignored.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    #1;
    check("t4_no_halt", {31'd0, halted}, 0);
    check("t4_req", {31'd0, bus.imem_req}, 1);
    bus.imem_ready = 1'b1;
    push(16'h5500, 4'd6);
    tick();
    bus.imem_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    #1;
    check("t4_commit", {31'd0, commit}, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("t4_halted", {31'd0, halted}, 1);
      check("t4_nocommit", {31'd0, commit}, 0);
      check("t4_noreq", {31'd0, bus.imem_req}, 0);
    end
    check("t4_instret7", {28'd0, instret}, 7);
    halt_req = 1'b0;

    // Reset mid-MEM abandons the access.
    bus.imem_rdata = 16'h0004;
    bus.imem_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    #1;
    check("t5_mem_req", {31'd0, bus.dmem_req}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dmem_ready = 1'b1;
    #1;
    check("t5_outs",
          {bus.imem_req, bus.dmem_req, bus.dmem_we,
           commit, running, halted, fault}, 0);
    check("t5_instret", {28'd0, instret}, 0);
    tick();
    bus.dmem_ready = 1'b0;
    #1;
    check("t5_idle", {31'd0, running}, 0);
    check("t5_nocommit", {31'd0, commit}, 0);

    // Sixteen ADDIs wrap the 4-bit counter.
    bus.imem_rdata = 16'h5500;
    bus.imem_ready = 1'b1;
    run = 1'b1;
    for (int n = 0; n < 16; n++)
      push(16'h5500, 4'(n));
    for (int n = 0; n < 16; n++) begin
      tick();
      tick();
      tick();
      if (n == 15) begin
        halt_req = 1'b1;
        run = 1'b0;
      end
      #1;
      check("t6_commit", {31'd0, commit}, 1);
      check("t6_instret", {28'd0, instret}, n);
    end
    tick();
    halt_req = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    check("t6_wrap", {28'd0, instret}, 0);
    check("t6_halted", {31'd0, halted}, 1);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
